// File: rtl/display_arbiter.sv
// Two-source display arbiter for a four-digit driver: source A owns the display
// by default, source B gets it on request for a minimum hold, then a guard gap.
module display_arbiter #(
  parameter int unsigned HOLD_TICKS  = 8,
  parameter int unsigned GUARD_TICKS = 4,
  parameter int unsigned BLINK_DIV   = 4
) (
  input  logic        display_clk,
  input  logic        i_rst,
  input  logic [15:0] a_digits,
  input  logic [3:0]  a_blink,
  input  logic        b_req,
  input  logic [15:0] b_digits,
  output logic        b_gnt,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic [3:0]  dig4,
  output logic        owner
);

  typedef enum logic [1:0] {
    SHOW_A = 2'd0,
    SHOW_B = 2'd1,
    GUARD  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_TICKS - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [7:0]  guard_cnt;
  logic [7:0]  blink_cnt;
  logic        blink_phase;
  logic [15:0] b_latch;
  logic [15:0] a_shown;

  // NOTE: a_shown gets its full default before the per-digit overrides, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_shown = a_digits;
    for (int n = 0; n < 4; n++) begin
      if (a_blink[n] && blink_phase) a_shown[4*n +: 4] = 4'hF;
    end
  end

  // NOTE: every register below is updated with <= so all of them sample the
  // pre-edge values of each other, which is what makes the outputs registered.
  always_ff @(posedge display_clk) begin
    if (i_rst) begin
      state                    <= SHOW_A;
      hold_cnt                 <= '0;
      guard_cnt                <= '0;
      blink_cnt                <= '0;
      blink_phase              <= 1'b0;
      b_latch                  <= 16'hFFFF;
      b_gnt                    <= 1'b0;
      owner                    <= 1'b0;
      {dig4, dig3, dig2, dig1} <= 16'hFFFF;
    end else begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end

      case (state)
        SHOW_A: begin
          if (b_req) begin
            state                    <= SHOW_B;
            hold_cnt                 <= '0;
            b_gnt                    <= 1'b1;
            owner                    <= 1'b1;
            b_latch                  <= b_digits;
            {dig4, dig3, dig2, dig1} <= b_digits;
          end else begin
            {dig4, dig3, dig2, dig1} <= a_shown;
          end
        end

        SHOW_B: begin
          if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
          // B only lets go once the minimum hold has elapsed and it stops asking.
          if (!b_req && (hold_cnt == HOLD_LAST)) begin
            state                    <= GUARD;
            guard_cnt                <= '0;
            b_gnt                    <= 1'b0;
            owner                    <= 1'b0;
            {dig4, dig3, dig2, dig1} <= a_shown;
          end else if (b_req) begin
            b_latch                  <= b_digits;
            {dig4, dig3, dig2, dig1} <= b_digits;
          end else begin
            {dig4, dig3, dig2, dig1} <= b_latch;
          end
        end

        GUARD: begin
          {dig4, dig3, dig2, dig1} <= a_shown;
          if (guard_cnt == GUARD_LAST) begin
            state <= SHOW_A;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end

        default: begin
          state                    <= SHOW_A;
          b_gnt                    <= 1'b0;
          owner                    <= 1'b0;
          {dig4, dig3, dig2, dig1} <= 16'hFFFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter at default parameters: a cycle-by-cycle
// vector table plus hand-written long-hold and reset-in-GUARD sequences.
module tb_display_arbiter;

  logic        display_clk = 1'b0;
  logic        i_rst       = 1'b1;
  logic [15:0] a_digits    = '0;
  logic [3:0]  a_blink     = '0;
  logic        b_req       = 1'b0;
  logic [15:0] b_digits    = '0;
  logic        b_gnt;
  logic [3:0]  dig1, dig2, dig3, dig4;
  logic        owner;

  int n_checks = 0;
  int n_fail   = 0;

  display_arbiter #(
    .HOLD_TICKS (8),
    .GUARD_TICKS(4),
    .BLINK_DIV  (4)
  ) dut (
    .display_clk(display_clk),
    .i_rst      (i_rst),
    .a_digits   (a_digits),
    .a_blink    (a_blink),
    .b_req      (b_req),
    .b_digits   (b_digits),
    .b_gnt      (b_gnt),
    .dig1       (dig1),
    .dig2       (dig2),
    .dig3       (dig3),
    .dig4       (dig4),
    .owner      (owner)
  );

  always #5 display_clk = ~display_clk;

  typedef struct packed {
    logic        rst;
    logic [15:0] a;
    logic [3:0]  blink;
    logic        req;
    logic [15:0] b;
    logic        gnt;
    logic        own;
    logic [15:0] dig;   // {dig4,dig3,dig2,dig1}
  } vec_t;

  localparam int NVEC = 30;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, take one rising edge, sample 1 ns later.
  task automatic step(input logic rst, input logic [15:0] a, input logic [3:0] blink,
                      input logic req, input logic [15:0] b);
    @(negedge display_clk);
    i_rst    = rst;
    a_digits = a;
    a_blink  = blink;
    b_req    = req;
    b_digits = b;
    @(posedge display_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic gnt, input logic own, input logic [15:0] dig);
    check({tag, " b_gnt"}, {15'd0, b_gnt}, {15'd0, gnt});
    check({tag, " owner"}, {15'd0, owner}, {15'd0, own});
    check({tag, " digits"}, {dig4, dig3, dig2, dig1}, dig);
  endtask

  initial begin
    // Table: rows are consecutive cycles; blink phase is tracked from the reset row.
    //            rst   a_digits  blink  req   b_digits  gnt   own   {dig4..dig1}
    tbl[0]  = {1'b1, 16'h1234, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
    tbl[1]  = {1'b0, 16'h1234, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[2]  = {1'b0, 16'h1234, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[3]  = {1'b0, 16'hABCD, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hABCD};
    tbl[4]  = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[5]  = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h123F};
    tbl[6]  = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h123F};
    tbl[7]  = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h123F};
    tbl[8]  = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h123F};
    tbl[9]  = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[10] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h9876, 1'b1, 1'b1, 16'h9876};
    tbl[11] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[12] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[13] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[14] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[15] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[16] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[17] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9876};
    tbl[18] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[19] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h1234};
    tbl[20] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h1234};
    tbl[21] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h123F};
    tbl[22] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h123F};
    tbl[23] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h5555, 1'b1, 1'b1, 16'h5555};
    tbl[24] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h0123, 1'b1, 1'b1, 16'h0123};
    tbl[25] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h4567, 1'b1, 1'b1, 16'h4567};
    tbl[26] = {1'b0, 16'h1234, 4'h1, 1'b1, 16'h89AB, 1'b1, 1'b1, 16'h89AB};
    tbl[27] = {1'b1, 16'h1234, 4'h1, 1'b1, 16'h89AB, 1'b0, 1'b0, 16'hFFFF};
    tbl[28] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[29] = {1'b0, 16'h1234, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].rst, tbl[i].a, tbl[i].blink, tbl[i].req, tbl[i].b);
      expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].own, tbl[i].dig);
    end

    // Long hold: B keeps requesting for 20 cycles with fresh data every cycle.
    step(1'b1, 16'h2468, 4'h0, 1'b0, 16'h0000);
    expect_out("hold reset", 1'b0, 1'b0, 16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] bd;
      bd = 16'h1000 + 16'(i * 16'h0357);
      step(1'b0, 16'h2468, 4'h0, 1'b1, bd);
      expect_out($sformatf("hold cyc%0d", i), 1'b1, 1'b1, bd);
    end
    // Hold already satisfied, so the first idle cycle hands the display back.
    step(1'b0, 16'h2468, 4'h0, 1'b0, 16'h0000);
    expect_out("hold release", 1'b0, 1'b0, 16'h2468);
    // Requests during GUARD and on its exit cycle are not granted.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h2468, 4'h0, 1'b1, 16'h7777);
      expect_out($sformatf("guard req%0d", i), 1'b0, 1'b0, 16'h2468);
    end
    step(1'b0, 16'h2468, 4'h0, 1'b1, 16'h7777);
    expect_out("post-guard grant", 1'b1, 1'b1, 16'h7777);

    // Reset in the middle of GUARD: first cycle after reset must act as SHOW_A.
    step(1'b1, 16'h1357, 4'h0, 1'b0, 16'h0000);
    step(1'b0, 16'h1357, 4'h0, 1'b1, 16'hAAAA);
    expect_out("grd grant", 1'b1, 1'b1, 16'hAAAA);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h1357, 4'h0, 1'b0, 16'h0000);
    end
    expect_out("grd entered", 1'b0, 1'b0, 16'h1357);
    step(1'b1, 16'h1357, 4'h0, 1'b1, 16'hBBBB);
    expect_out("grd reset", 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 16'h1357, 4'h0, 1'b1, 16'hC0DE);
    expect_out("grd after reset", 1'b1, 1'b1, 16'hC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 8: minimum display_clk cycles source B owns the display once granted (legal range 1..255).
REQ-002 SHALL have parameter GUARD_TICKS, default 4: display_clk cycles after B releases during which B requests are ignored (legal range 1..255).
REQ-003 SHALL have parameter BLINK_DIV, default 4: display_clk cycles per blink half-period (legal range 1..255).
REQ-004 display_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 a_digits  input  16  source A (default owner) digits; [3:0]=dig1 … [15:12]=dig4.
REQ-007 a_blink  input  4  per-digit blink enable for source A; bit n maps to dig(n+1).
REQ-008 b_req  input  1  source B request for the display.
REQ-009 b_digits  input  16  source B digits, same packing as a_digits.
REQ-010 b_gnt  output  1  high while B owns the display.
REQ-011 dig1, dig2, dig3, dig4  output  4 each  digit codes to the four-digit driver; 4'hF = blank.
REQ-012 owner  output  1  0 = A shown, 1 = B shown.

Function
REQ-013 SHALL implement three states: SHOW_A, SHOW_B, GUARD; all outputs registered.
REQ-014 SHOW_A: if b_req=1, next state SHOW_B, hold counter cleared to 0, b_gnt=1 and owner=1 from the following cycle.
REQ-015 SHOW_B: hold counter increments each cycle, saturating at HOLD_TICKS-1.
REQ-016 SHOW_B: transition to GUARD only when b_req=0 AND hold counter = HOLD_TICKS-1; b_gnt and owner drop to 0 in the same cycle state becomes GUARD.
REQ-017 SHOW_B with b_req held high: remain in SHOW_B indefinitely (no timeout).
REQ-018 b_digits latched into an internal 16-bit register every cycle b_req=1 while in SHOW_B or on the SHOW_A->SHOW_B transition; when b_req=0 in SHOW_B the last latched value is displayed.
REQ-019 GUARD: guard counter counts 0..GUARD_TICKS-1, then next state SHOW_A; b_req ignored throughout GUARD.
REQ-020 In SHOW_A and GUARD, digN = a_digits nibble, except digN = 4'hF when a_blink[N-1]=1 and blink_phase=1.
REQ-021 In SHOW_B, digN = latched B nibble; a_blink has no effect.
REQ-022 Digit outputs SHALL reflect inputs with exactly one display_clk cycle latency; nibble values 10..15 pass through unmodified.
REQ-023 blink counter free-running in all states, 0..BLINK_DIV-1; blink_phase toggles when counter wraps from BLINK_DIV-1 to 0.
REQ-024 b_req rising in the same cycle as the GUARD->SHOW_A transition is not granted that cycle; it is granted on the next cycle if still high.
REQ-025 All counters SHALL be sized for the 255 maximum and never wrap in SHOW_B or GUARD.

Reset
REQ-026 i_rst=1 at a display_clk edge SHALL force: state SHOW_A, b_gnt=0, owner=0, dig1..dig4=4'hF, hold/guard/blink counters 0, blink_phase 0, latched B data 16'hFFFF.
REQ-027 Reset SHALL take priority over all other inputs, including mid-SHOW_B and mid-GUARD; first non-reset cycle behaves as SHOW_A.

Verification
REQ-028 Reset then a_digits=16'h1234, a_blink=0, b_req=0 -> after 1 cycle dig4..dig1=1,2,3,4, owner=0, b_gnt=0; stable indefinitely.
REQ-029 a_blink=4'b0001, BLINK_DIV=4 -> dig1 alternates 4 (4 cycles) / F (4 cycles); dig2..dig4 constant.
REQ-030 b_req 1-cycle pulse with b_digits=16'h9876, HOLD_TICKS=8 -> b_gnt high exactly 8 cycles showing 9,8,7,6, then 4 GUARD cycles of A, then SHOW_A.
REQ-031 b_req held high 20 cycles, b_digits changing each cycle -> b_gnt high 20 cycles, digits track b_digits with 1-cycle latency; drop after b_req falls (hold satisfied).
REQ-032 b_req re-asserted during GUARD -> ignored; grant occurs exactly on the cycle after GUARD->SHOW_A.
REQ-033 i_rst asserted at hold count 3 in SHOW_B -> next cycle b_gnt=0, owner=0, all digits F; following cycle A digits shown.
